// File: rtl/axi_burst_writer.sv
// axi_burst_writer: converts a (start_addr, num_beats) command plus a valid/ready
// word stream into AXI4 INCR write bursts. Bursts are split at MAX_BURST beats and
// at 4 KB pages, B responses are counted against MAX_OUTSTANDING, and any SLVERR or
// DECERR response raises a sticky error flag that is cleared by the next start.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   start/start_addr/num_beats     command (accepted only while busy=0)
//   busy/done/error                status (done is a 1-cycle pulse)
//   s_data_valid/ready/s_data      upstream word stream (passed through to W)
//   m_axi_aw*/m_axi_w*/m_axi_b*    AXI4 write-address, write-data and response channels
module axi_burst_writer #(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned MAX_BURST       = 64,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   start_addr,
  input  logic [LEN_WIDTH-1:0]    num_beats,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [1:0]              m_axi_awburst,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  input  logic [1:0]              m_axi_bresp,
  input  logic [ID_WIDTH-1:0]     m_axi_bid
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned SIZE  = $clog2(BYTES);
  localparam int unsigned OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BCW   = 9;

  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_WAIT_B} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [BCW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [7:0]             awlen_q, awlen_d;
  logic [OW-1:0]          outstanding_q, outstanding_d;
  logic                   awvalid_q, awvalid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic aw_hs, w_hs, b_hs, last_beat;
  logic unused_bits;

  // Beats in the next burst: limited by what is left, MAX_BURST and the 4 KB page end.
  function automatic logic [BCW-1:0] calc_len(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [LEN_WIDTH-1:0]  rem);
    logic [12:0]          page_beats;
    logic [LEN_WIDTH-1:0] len;
    page_beats = (13'd4096 - {1'b0, a[11:0]}) >> SIZE;
    len = rem;
    if (len > LEN_WIDTH'(MAX_BURST))  len = LEN_WIDTH'(MAX_BURST);
    if (len > LEN_WIDTH'(page_beats)) len = LEN_WIDTH'(page_beats);
    return BCW'(len);
  endfunction

  assign aw_hs     = awvalid_q & m_axi_awready;
  assign w_hs      = (state_q == S_W) & s_data_valid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign last_beat = w_hs & (beat_cnt_q == BCW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (num_beats == '0) ? S_WAIT_B : S_AW;
      S_AW:     if (aw_hs) state_d = S_W;
      S_W:      if (last_beat) state_d = (remaining_q == '0) ? S_WAIT_B : S_AW;
      S_WAIT_B: if (outstanding_q == '0) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    beat_cnt_d    = beat_cnt_q;
    awlen_d       = awlen_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;

    if ((state_q == S_IDLE) && start) begin
      addr_d      = start_addr & ~ADDR_WIDTH'(BYTES - 1);
      remaining_d = num_beats;
      error_d     = 1'b0;
    end

    if (aw_hs) begin
      addr_d      = addr_q + ((ADDR_WIDTH'(awlen_q) + ADDR_WIDTH'(1)) << SIZE);
      remaining_d = remaining_q - (LEN_WIDTH'(awlen_q) + LEN_WIDTH'(1));
      beat_cnt_d  = BCW'(awlen_q) + BCW'(1);
    end

    if (w_hs) beat_cnt_d = beat_cnt_q - BCW'(1);

    // Simultaneous AW and B handshakes cancel out.
    if (aw_hs && !b_hs)
      outstanding_d = outstanding_q + OW'(1);
    else if (!aw_hs && b_hs && (outstanding_q != '0))
      outstanding_d = outstanding_q - OW'(1);

    if (b_hs && m_axi_bresp[1]) error_d = 1'b1;

    // Burst length is fixed on AW entry so the AW fields stay stable while waiting.
    if ((state_d == S_AW) && (state_q != S_AW))
      awlen_d = 8'(calc_len(addr_d, remaining_d) - BCW'(1));

    // Stays high once raised: outstanding can only grow through our own handshake.
    awvalid_d = (state_d == S_AW) && (outstanding_d < OW'(MAX_OUTSTANDING));
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_WAIT_B) && (outstanding_q == '0);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      beat_cnt_q    <= '0;
      awlen_q       <= '0;
      outstanding_q <= '0;
      awvalid_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      beat_cnt_q    <= beat_cnt_d;
      awlen_q       <= awlen_d;
      outstanding_q <= outstanding_d;
      awvalid_q     <= awvalid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;

  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awsize  = 3'(SIZE);
  assign m_axi_awid    = '0;

  // W is a zero-latency pass-through of the upstream stream while in W.
  assign m_axi_wvalid  = (state_q == S_W) & s_data_valid;
  assign s_data_ready  = (state_q == S_W) & m_axi_wready;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == S_W) & (beat_cnt_q == BCW'(1));

  assign m_axi_bready  = rst_n;

  assign unused_bits   = ^{m_axi_bid, m_axi_bresp[0]};

endmodule

// File: tb/tb_axi_burst_writer.sv
// Testbench for axi_burst_writer: table of transfers with hand-computed AW
// addresses/lengths plus directed sequences for zero-length, outstanding stall,
// start-while-busy and reset-mid-burst. A small AXI slave model logs AW/W/B.
module tb_axi_burst_writer;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [63:0]    start_addr;
  logic [31:0]    num_beats;
  logic           busy, done, error;
  logic           s_data_valid, s_data_ready;
  logic [511:0]   s_data;
  logic           awvalid, awready;
  logic [63:0]    awaddr;
  logic [1:0]     awburst;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [3:0]     awid;
  logic           wvalid, wready, wlast;
  logic [511:0]   wdata;
  logic [63:0]    wstrb;
  logic           bvalid, bready;
  logic [1:0]     bresp;
  logic [3:0]     bid;

  axi_burst_writer #(
    .ADDR_WIDTH(64), .DATA_WIDTH(512), .ID_WIDTH(4), .LEN_WIDTH(32),
    .MAX_BURST(64), .MAX_OUTSTANDING(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .num_beats(num_beats), .busy(busy), .done(done), .error(error),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data(s_data),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awburst(awburst), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awid(awid), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_bid(bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] mk_word(input int unsigned i);
    return {8{64'(i) ^ 64'hA5A5_0000_0000_0000}};
  endfunction

  // ---------------- slave / stream model ----------------
  logic [63:0]  aw_addr_q[$];
  logic [7:0]   aw_len_q[$];
  logic [511:0] w_data_q[$];
  int  pending_b, out_cnt, b_idx, w_burst, w_beat, s_idx, s_total;
  int  done_cnt, proto_err, cfg_err_burst;
  bit  cfg_gaps, cfg_b_hold, s_keep, err_at_done;

  initial begin
    awready = 1'b0; wready = 1'b0; s_data_valid = 1'b0; s_data = '0;
    bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    pending_b = 0; out_cnt = 0; b_idx = 0; w_burst = 0; w_beat = 0; s_idx = 0;
    s_total = 0; done_cnt = 0; proto_err = 0; cfg_err_burst = -1;
    cfg_gaps = 1'b0; cfg_b_hold = 1'b0; s_keep = 1'b0; err_at_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (awvalid && awready) begin
          aw_addr_q.push_back(awaddr);
          aw_len_q.push_back(awlen);
          out_cnt++;
          if (out_cnt > 8) proto_err++;
          if ((int'(awaddr[11:0]) + (int'(awlen) + 1) * 64) > 4096) proto_err++;
        end
        s_keep = s_data_valid && !s_data_ready;
        if (wvalid && wready) begin
          if (w_burst >= aw_len_q.size()) proto_err++;
          else begin
            if (wlast != (w_beat == int'(aw_len_q[w_burst]))) proto_err++;
            if (w_beat == int'(aw_len_q[w_burst])) begin
              w_burst++; w_beat = 0; pending_b++;
            end else w_beat++;
          end
          if (wstrb != '1) proto_err++;
          w_data_q.push_back(wdata);
          s_idx++;
        end
        if (bvalid && bready) begin
          out_cnt--; pending_b--; b_idx++;
        end
        if (done) begin
          done_cnt++;
          err_at_done = error;
        end
      end
      @(posedge clk);
      #1;
      awready = cfg_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = cfg_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_keep)
        s_data_valid = (s_idx < s_total) && (cfg_gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      s_data = mk_word(s_idx);
      bvalid = (pending_b > 0) && !cfg_b_hold && (cfg_gaps ? ($urandom_range(0, 1) == 1) : 1'b1);
      bresp  = (b_idx == cfg_err_burst) ? 2'b10 : 2'b00;
    end
  end

  task automatic clear_bfm(input int total, input bit gaps, input int err_burst);
    aw_addr_q.delete(); aw_len_q.delete(); w_data_q.delete();
    pending_b = 0; out_cnt = 0; b_idx = 0; w_burst = 0; w_beat = 0; s_idx = 0;
    done_cnt = 0; proto_err = 0; err_at_done = 1'b0; s_keep = 1'b0;
    s_total = total; cfg_gaps = gaps; cfg_err_burst = err_burst; cfg_b_hold = 1'b0;
    bvalid = 1'b0;
  endtask

  task automatic check_data(input string tag, input int nb);
    int mism;
    mism = 0;
    check({tag, " beat count"}, 64'(w_data_q.size()), 64'(nb));
    foreach (w_data_q[i]) if (w_data_q[i] !== mk_word(i)) mism++;
    check({tag, " data order"}, 64'(mism), 64'd0);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && done_cnt == 0; c++) tick();
    repeat (3) tick();
  endtask

  // ---------------- transfer table ----------------
  typedef struct packed {
    logic [63:0]      addr;
    logic [31:0]      nb;
    logic             gaps;
    int               err_burst;
    logic             exp_err;
    logic [31:0]      n_aw;
    logic [2:0][63:0] exp_addr;
    logic [2:0][7:0]  exp_len;
  } vec_t;

  vec_t vecs[8];

  task automatic set_vec(input int i, input logic [63:0] addr, input int nb, input bit gaps,
                         input int err_burst, input bit exp_err, input int n_aw,
                         input logic [63:0] a0, input logic [7:0] l0,
                         input logic [63:0] a1, input logic [7:0] l1,
                         input logic [63:0] a2, input logic [7:0] l2);
    vecs[i].addr = addr;  vecs[i].nb = 32'(nb); vecs[i].gaps = gaps;
    vecs[i].err_burst = err_burst; vecs[i].exp_err = exp_err; vecs[i].n_aw = 32'(n_aw);
    vecs[i].exp_addr[0] = a0; vecs[i].exp_len[0] = l0;
    vecs[i].exp_addr[1] = a1; vecs[i].exp_len[1] = l1;
    vecs[i].exp_addr[2] = a2; vecs[i].exp_len[2] = l2;
  endtask

  task automatic run_transfer(input int r);
    string t;
    t = $sformatf("row%0d", r);
    clear_bfm(int'(vecs[r].nb), vecs[r].gaps, vecs[r].err_burst);
    start_addr = vecs[r].addr; num_beats = vecs[r].nb; start = 1'b1;
    tick();
    start = 1'b0;
    check({t, " busy after start"}, 64'(busy), 64'd1);
    check({t, " error cleared by start"}, 64'(error), 64'd0);
    wait_done(3000);
    check({t, " done pulses"}, 64'(done_cnt), 64'd1);
    check({t, " error at done"}, 64'(err_at_done), 64'(vecs[r].exp_err));
    check({t, " busy after done"}, 64'(busy), 64'd0);
    check({t, " aw count"}, 64'(aw_addr_q.size()), 64'(vecs[r].n_aw));
    for (int k = 0; k < int'(vecs[r].n_aw) && k < aw_addr_q.size(); k++) begin
      check($sformatf("%s awaddr[%0d]", t, k), aw_addr_q[k], vecs[r].exp_addr[k]);
      check($sformatf("%s awlen[%0d]", t, k), 64'(aw_len_q[k]), 64'(vecs[r].exp_len[k]));
    end
    check_data(t, int'(vecs[r].nb));
    check({t, " protocol"}, 64'(proto_err), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; start_addr = '0; num_beats = '0;
    repeat (3) @(posedge clk);
    #2;
    check("reset outputs", 64'({busy, done, error, awvalid, wvalid, wlast, s_data_ready, bready}), 64'd0);
    check("awburst", 64'(awburst), 64'd1);
    check("awsize", 64'(awsize), 64'd6);
    check("awid", 64'(awid), 64'd0);
    check("wstrb all ones", 64'(&wstrb), 64'd1);
    rst_n = 1'b1;
    tick();
    check("bready after reset", 64'(bready), 64'd1);
    check("reset awaddr/awlen", {awaddr[55:0], awlen}, 64'd0);

    //        row addr                   nb   gaps err exp n  a0/l0                     a1/l1                      a2/l2
    set_vec(0, 64'h1000,                 16,  0, -1, 0, 1, 64'h1000, 8'd15, 64'h0, 8'd0, 64'h0, 8'd0);
    set_vec(1, 64'h0,                   150,  0, -1, 0, 3, 64'h0, 8'd63, 64'h1000, 8'd63, 64'h2000, 8'd21);
    set_vec(2, 64'h0FC0,                  4,  0, -1, 0, 2, 64'h0FC0, 8'd0, 64'h1000, 8'd2, 64'h0, 8'd0);
    set_vec(3, 64'h1F80,                 70,  0, -1, 0, 3, 64'h1F80, 8'd1, 64'h2000, 8'd63, 64'h3000, 8'd3);
    set_vec(4, 64'h103F,                 16,  0, -1, 0, 1, 64'h1000, 8'd15, 64'h0, 8'd0, 64'h0, 8'd0);
    set_vec(5, 64'h0,                   150,  1,  1, 1, 3, 64'h0, 8'd63, 64'h1000, 8'd63, 64'h2000, 8'd21);
    set_vec(6, 64'h1000,                 16,  1, -1, 0, 1, 64'h1000, 8'd15, 64'h0, 8'd0, 64'h0, 8'd0);
    set_vec(7, 64'h0000_0001_0000_0F80,   3,  0, -1, 0, 2, 64'h0000_0001_0000_0F80, 8'd1,
            64'h0000_0001_0000_1000, 8'd0, 64'h0, 8'd0);
    for (int r = 0; r < 8; r++) run_transfer(r);

    // Zero-length command: straight to completion, done two cycles after start.
    clear_bfm(0, 1'b0, -1);
    start_addr = 64'h2000; num_beats = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero-len cycle1 busy", 64'(busy), 64'd1);
    check("zero-len cycle1 done", 64'(done), 64'd0);
    tick();
    check("zero-len cycle2 done", 64'(done), 64'd1);
    check("zero-len cycle2 busy", 64'(busy), 64'd0);
    tick();
    check("zero-len cycle3 done", 64'(done), 64'd0);
    check("zero-len no AW/W", 64'(aw_addr_q.size() + w_data_q.size()), 64'd0);

    // B withheld: AW must stop at 8 outstanding, W for issued bursts still drains.
    clear_bfm(600, 1'b0, -1);
    cfg_b_hold = 1'b1;
    start_addr = 64'h0; num_beats = 32'd600; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (700) tick();
    check("stall aw count", 64'(aw_addr_q.size()), 64'd8);
    check("stall w beats", 64'(w_data_q.size()), 64'd512);
    check("stall awvalid low", 64'(awvalid), 64'd0);
    check("stall busy", 64'(busy), 64'd1);
    start_addr = 64'h5000_0000; num_beats = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    cfg_b_hold = 1'b0;
    wait_done(3000);
    check("stall done pulses", 64'(done_cnt), 64'd1);
    check("stall aw total", 64'(aw_addr_q.size()), 64'd10);
    for (int k = 0; k < aw_addr_q.size(); k++) begin
      check($sformatf("stall awaddr[%0d]", k), aw_addr_q[k], 64'(k) * 64'h1000);
      check($sformatf("stall awlen[%0d]", k), 64'(aw_len_q[k]), (k == 9) ? 64'd23 : 64'd63);
    end
    check_data("stall", 600);
    check("stall protocol", 64'(proto_err), 64'd0);

    // Reset in the middle of the second burst, after an SLVERR on the first.
    clear_bfm(150, 1'b0, 0);
    start_addr = 64'h0; num_beats = 32'd150; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 500 && w_data_q.size() < 70; c++) tick();
    check("pre-reset error", 64'(error), 64'd1);
    check("pre-reset wvalid", 64'(wvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid-reset outputs",
          64'({busy, done, error, awvalid, wvalid, wlast, s_data_ready, bready}), 64'd0);
    check("mid-reset awaddr/awlen", {awaddr[55:0], awlen}, 64'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    run_transfer(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
